// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit.
//   DEFAULT_WIDTH : default operand/result width
//   OP_MUL/OP_DIV : encoding of the 'op' input
//   state_t       : control FSM states
// Optional feature macro used by the unit: MULDIV_SIGNED_EN
// -----------------------------------------------------------------------------
package muldiv_pkg;
    localparam int DEFAULT_WIDTH = 16;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;
endpackage

// File: rtl/muldiv_signfix.sv
// -----------------------------------------------------------------------------
// muldiv_signfix
// Combinational conditional two's-complement negate.
// Ports:
//   value : WIDTH-bit input value
//   neg   : 1 = negate, 0 = pass through
//   fixed : WIDTH-bit result
// -----------------------------------------------------------------------------
module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    input  logic             neg,
    output logic [WIDTH-1:0] fixed
);
    assign fixed = neg ? (~value + WIDTH'(1)) : value;
endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative multi-cycle multiply/divide for the EX stage. One bit step per
// cycle (shift-add multiply, restoring divide), then a sign/exception fix
// cycle, then a one-cycle 'done' pulse. Latency start->done = WIDTH+2 cycles.
//
// Parameters:
//   WIDTH     : operand/result width (>= 4, even)
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous active-high reset
//   start     : request, sampled only in IDLE
//   op        : 0 = multiply, 1 = divide
//   sgn       : 1 = signed operands (only with MULDIV_SIGNED_EN)
//   flush     : synchronous cancel of the current operation
//   a, b      : multiplicand/dividend, multiplier/divisor
//   busy      : operation in flight (CALC/FIX), drops when done rises
//   done      : one-cycle completion pulse
//   result    : product low half or quotient
//   remainder : product high half or remainder
//   o         : overflow / exception flag
//
// Configuration macro: MULDIV_SIGNED_EN
//   defined   : signed operation honoured (magnitude conversion + sign fix)
//   undefined : all operations unsigned, 'sgn' ignored, same latency
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             sgn,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             o
);
    localparam int                CNT_W   = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]  LAST    = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]  MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state;
    logic [CNT_W-1:0]   count;

    // Shared accumulator: multiply = {partial product, multiplier bits},
    // divide = {partial remainder, dividend/quotient bits}.
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_sub;

    // Latched operation context
    logic [WIDTH-1:0]   ma;
    logic [WIDTH-1:0]   mb;
    logic [WIDTH-1:0]   a_lat;
    logic               op_lat;
    logic               neg_a;
    logic               neg_b;
    logic               sgn_lat;
    logic               min_ovf;

    // Input-side sign handling
    logic               sgn_on;
    logic               a_neg_in;
    logic               b_neg_in;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    // Sign-corrected results evaluated in FIX
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic               mul_ovf;
    logic [WIDTH-1:0]   fix_lo;
    logic [WIDTH-1:0]   fix_hi;
    logic               fix_o;

`ifdef MULDIV_SIGNED_EN
    assign sgn_on   = sgn;
    assign a_neg_in = sgn & a[WIDTH-1];
    assign b_neg_in = sgn & b[WIDTH-1];

    muldiv_signfix #(.WIDTH(WIDTH)) u_mag_a (
        .value (a),
        .neg   (a_neg_in),
        .fixed (mag_a)
    );

    muldiv_signfix #(.WIDTH(WIDTH)) u_mag_b (
        .value (b),
        .neg   (b_neg_in),
        .fixed (mag_b)
    );

    muldiv_signfix #(.WIDTH(2*WIDTH)) u_fix_prod (
        .value (acc),
        .neg   (neg_a ^ neg_b),
        .fixed (prod)
    );

    // Quotient truncates toward zero: negate when signs differ.
    muldiv_signfix #(.WIDTH(WIDTH)) u_fix_quot (
        .value (acc[WIDTH-1:0]),
        .neg   (neg_a ^ neg_b),
        .fixed (quot)
    );

    // Remainder follows the dividend's sign.
    muldiv_signfix #(.WIDTH(WIDTH)) u_fix_rem (
        .value (acc[2*WIDTH-1:WIDTH]),
        .neg   (neg_a),
        .fixed (rem)
    );

    assign mul_ovf = (prod[2*WIDTH-1:WIDTH] != {WIDTH{sgn_lat & prod[WIDTH-1]}});
`else
    logic unused_sgn;

    assign sgn_on     = 1'b0;
    assign a_neg_in   = 1'b0;
    assign b_neg_in   = 1'b0;
    assign mag_a      = a;
    assign mag_b      = b;
    assign prod       = acc;
    assign quot       = acc[WIDTH-1:0];
    assign rem        = acc[2*WIDTH-1:WIDTH];
    assign mul_ovf    = |acc[2*WIDTH-1:WIDTH];
    assign unused_sgn = ^{sgn, neg_a, neg_b, sgn_lat};
`endif

    // One iteration of the selected algorithm.
    always_comb begin
        acc_step  = acc;
        mul_sum   = '0;
        div_shift = '0;
        div_sub   = '0;
        if (op_lat == OP_MUL) begin
            mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, ma} : '0);
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end else begin
            // Bring the next dividend bit into the partial remainder and
            // keep the trial subtraction only if it does not go negative.
            div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
            div_sub   = div_shift - {1'b0, mb};
            if (div_shift >= {1'b0, mb})
                acc_step = {div_sub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    // Final output selection including the exception cases.
    always_comb begin
        fix_lo = prod[WIDTH-1:0];
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_o  = mul_ovf;
        if (op_lat == OP_DIV) begin
            if (mb == '0) begin
                fix_lo = '1;
                fix_hi = a_lat;
                fix_o  = 1'b1;
            end else if (min_ovf) begin
                fix_lo = MIN_VAL;
                fix_hi = '0;
                fix_o  = 1'b1;
            end else begin
                fix_lo = quot;
                fix_hi = rem;
                fix_o  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            remainder <= '0;
            o         <= 1'b0;
            acc       <= '0;
            ma        <= '0;
            mb        <= '0;
            a_lat     <= '0;
            op_lat    <= OP_MUL;
            neg_a     <= 1'b0;
            neg_b     <= 1'b0;
            sgn_lat   <= 1'b0;
            min_ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        ma      <= mag_a;
                        mb      <= mag_b;
                        a_lat   <= a;
                        op_lat  <= op;
                        neg_a   <= a_neg_in;
                        neg_b   <= b_neg_in;
                        sgn_lat <= sgn_on;
                        min_ovf <= sgn_on && (a == MIN_VAL) && (b == '1);
                        acc     <= (op == OP_MUL) ? {{WIDTH{1'b0}}, mag_b}
                                                  : {{WIDTH{1'b0}}, mag_a};
                        count   <= '0;
                        busy    <= 1'b1;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        acc   <= acc_step;
                        count <= count + CNT_W'(1);
                        if (count == LAST)
                            state <= FIX;
                    end
                end
                FIX: begin
                    busy <= 1'b0;
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        result    <= fix_lo;
                        remainder <= fix_hi;
                        o         <= fix_o;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
